decode_issue_ctrl: RTL and testbench

- Single-entry issue stage between the decoder and the execute/data-memory stage.
- Holds one decoded instruction and tracks in-flight destination registers in a 32-bit scoreboard.
- Stalls the held instruction on RAW/WAW hazards and drops it on a pipeline flush.
- Throttles fetch/decode through a valid/ready handshake.

---
 rtl/decode_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl
//   Single-entry issue stage between the decoder and execute/dmem.
//   Holds one decoded instruction, tracks in-flight destinations in a
//   scoreboard, stalls on RAW/WAW hazards and drops the held instruction
//   on a flush. Fetch/decode is throttled by the in_valid/in_ready handshake.
//
// Optional feature macro: DECODE_ISSUE_STALL_CNT_EN
//   defined   : stall_cycles counts cycles spent in STALL (not flushing),
//               saturating at all-ones.
//   undefined : stall_cycles is tied to 0, no counter flops.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           decoder handshake
//   in_pc/opcode/rd/rs1/rs2     incoming decoded instruction
//   out_valid/out_ready         execute/dmem handshake
//   out_pc/opcode/rd/rs1/rs2    held instruction (shown even when !out_valid)
//   wb_valid, wb_rd             writeback retires a destination register
//   flush                       redirect, kill the held instruction
//   busy                        scoreboard, bit i = write to xi pending
//   stall_cycles                hazard-stall counter
// ---------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [31:0]     stall_cycles
);

    typedef enum logic [1:0] {EMPTY, STALL, READY} state_t;

    logic            r_held;
    logic [XLEN-1:0] r_pc;
    logic [6:0]      r_opcode;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [NREG-1:0] r_busy;

    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_writes_rd;
    logic [NREG-1:0] w_wb_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_eff;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_hazard;
    logic            w_issue;
    logic            w_accept;
    state_t          w_state;

    // Register usage is decoded from the held opcode only.
    always_comb begin
        w_uses_rs1  = r_opcode inside {7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};
        w_uses_rs2  = r_opcode inside {7'h63, 7'h23, 7'h33};
        w_writes_rd = (r_opcode inside {7'h37, 7'h17, 7'h6f, 7'h67,
                                        7'h03, 7'h13, 7'h33, 7'h73})
                      && (r_rd != 5'd0);
    end

    // Same-cycle writeback is removed before the hazard check so a
    // dependent instruction issues in the very cycle its source retires.
    assign w_wb_mask = (wb_valid && wb_rd != 5'd0) ? (NREG'(1) << wb_rd) : '0;
    assign w_eff     = r_busy & ~w_wb_mask;

    assign w_hazard = (w_uses_rs1 && w_eff[r_rs1]) ||
                      (w_uses_rs2 && w_eff[r_rs2]) ||
                      (w_writes_rd && w_eff[r_rd]);

    // State is re-derived every cycle: it depends on this cycle's writeback,
    // so only the "holding" bit is stored.
    always_comb begin
        w_state = EMPTY;
        if (r_held) w_state = w_hazard ? STALL : READY;
    end

    assign out_valid = (w_state == READY) && !flush;
    assign w_issue   = out_valid && out_ready;
    assign in_ready  = !flush && ((w_state == EMPTY) || w_issue);
    assign w_accept  = in_valid && in_ready;

    // Set after clear: the issuing instruction is younger than the retiring one.
    assign w_set_mask = (w_issue && w_writes_rd) ? (NREG'(1) << r_rd) : '0;
    always_comb begin
        w_busy_nxt    = w_eff | w_set_mask;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held   <= 1'b0;
            r_pc     <= '0;
            r_opcode <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_busy   <= '0;
        end else begin
            // Flush leaves busy alone apart from writeback: older ops are still in flight.
            r_busy <= w_busy_nxt;
            if (flush) begin
                r_held <= 1'b0;
            end else if (w_accept) begin
                r_held   <= 1'b1;
                r_pc     <= in_pc;
                r_opcode <= in_opcode;
                r_rd     <= in_rd;
                r_rs1    <= in_rs1;
                r_rs2    <= in_rs2;
            end else if (w_issue) begin
                r_held <= 1'b0;
            end
        end
    end

    assign out_pc     = r_pc;
    assign out_opcode = r_opcode;
    assign out_rd     = r_rd;
    assign out_rs1    = r_rs1;
    assign out_rs2    = r_rs2;
    assign busy       = r_busy;

`ifdef DECODE_ISSUE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_state == STALL && !flush && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] busy;
    logic [31:0] stall_cycles;

    decode_issue_ctrl #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int npop = 0;

`ifdef DECODE_ISSUE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of accepted instructions, compared when they issue.
    typedef struct { logic [31:0] pc; logic [6:0] op; } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL sb_underflow: issue of pc %h with nothing expected", out_pc);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    npop++;
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_opcode", {25'd0, out_opcode}, {25'd0, e.op});
                end
            end
            if (in_valid && in_ready) sb.push_back('{pc: in_pc, op: in_opcode});
        end
    end

    task automatic drive_in(input logic v, input logic [31:0] pc, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid = v; in_pc = pc; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive_in(0, 0, 0, 0, 0, 0);
        out_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        rst_n = 0;
        next_cyc(); next_cyc();
        rst_n = 1;
    endtask

    // Hazard decode vectors: busy[b] is set by a preceding lui xb, then
    // the test instruction is held and its stall decision checked.
    typedef struct {
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2, b;
        logic       stall;
    } vec_t;
    localparam int NV = 13;
    vec_t vt[NV];

    initial begin
        vt[0]  = '{op: 7'h33, rd: 9,  rs1: 5,  rs2: 1, b: 5,  stall: 1}; // add RAW rs1
        vt[1]  = '{op: 7'h33, rd: 9,  rs1: 1,  rs2: 6, b: 6,  stall: 1}; // add RAW rs2
        vt[2]  = '{op: 7'h23, rd: 7,  rs1: 1,  rs2: 7, b: 7,  stall: 1}; // sw rs2
        vt[3]  = '{op: 7'h37, rd: 7,  rs1: 0,  rs2: 0, b: 7,  stall: 1}; // lui WAW
        vt[4]  = '{op: 7'h0f, rd: 7,  rs1: 7,  rs2: 7, b: 7,  stall: 0}; // fence
        vt[5]  = '{op: 7'h37, rd: 0,  rs1: 0,  rs2: 0, b: 0,  stall: 0}; // x0 never busy
        vt[6]  = '{op: 7'h13, rd: 2,  rs1: 1,  rs2: 4, b: 4,  stall: 0}; // addi ignores rs2
        vt[7]  = '{op: 7'h6f, rd: 8,  rs1: 3,  rs2: 0, b: 3,  stall: 0}; // jal ignores rs1
        vt[8]  = '{op: 7'h67, rd: 8,  rs1: 3,  rs2: 0, b: 3,  stall: 1}; // jalr rs1
        vt[9]  = '{op: 7'h63, rd: 2,  rs1: 1,  rs2: 1, b: 2,  stall: 0}; // beq no rd write
        vt[10] = '{op: 7'h03, rd: 10, rs1: 1,  rs2: 0, b: 10, stall: 1}; // lw WAW
        vt[11] = '{op: 7'h73, rd: 1,  rs1: 12, rs2: 0, b: 12, stall: 0}; // csr ignores rs1
        vt[12] = '{op: 7'h17, rd: 13, rs1: 0,  rs2: 0, b: 13, stall: 1}; // auipc WAW

        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_busy", busy, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_out_pc", out_pc, 0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            logic [31:0] eb;
            eb = (vt[i].b == 0) ? 32'd0 : (32'd1 << vt[i].b);
            do_reset();
            out_ready = 1;
            drive_in(1, 32'h100, 7'h37, vt[i].b, 0, 0);
            next_cyc();
            drive_in(1, 32'h104, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 1);
            next_cyc();
            in_valid = 0; out_ready = 0;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, !vt[i].stall});
            chk($sformatf("vec%0d_busy", i), busy, eb);
            next_cyc();
        end

        // Back-to-back independent stream
        do_reset();
        out_ready = 1;
        drive_in(1, 32'h200, 7'h13, 1, 0, 0);
        next_cyc();
        drive_in(1, 32'h204, 7'h13, 2, 0, 0);
        @(negedge clk);
        chk("b2b_in_ready", {31'd0, in_ready}, 1);
        chk("b2b_out_valid0", {31'd0, out_valid}, 1);
        next_cyc();
        in_valid = 0;
        @(negedge clk);
        chk("b2b_out_valid1", {31'd0, out_valid}, 1);
        chk("b2b_out_pc1", out_pc, 32'h204);
        next_cyc();
        @(negedge clk);
        chk("b2b_empty", {31'd0, out_valid}, 0);
        chk("b2b_busy", busy, 32'h6);
        next_cyc();

        // RAW stall released by same-cycle writeback
        do_reset();
        out_ready = 1;
        drive_in(1, 32'h300, 7'h13, 5, 0, 0);
        next_cyc();
        drive_in(1, 32'h304, 7'h33, 6, 5, 0);
        next_cyc();
        in_valid = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin wb_valid = 1; wb_rd = 0; end  // x0 writeback is a no-op
            else wb_valid = 0;
            @(negedge clk);
            chk($sformatf("raw_stall%0d", c), {31'd0, out_valid}, 0);
            next_cyc();
        end
        wb_valid = 1; wb_rd = 5;
        @(negedge clk);
        chk("raw_release", {31'd0, out_valid}, 1);
        next_cyc();
        wb_valid = 0; wb_rd = 0;
        @(negedge clk);
        chk("raw_stall_cycles", stall_cycles, CNT_EN ? 32'd3 : 32'd0);
        chk("raw_busy", busy, 32'h40);
        next_cyc();

        // Backpressure
        do_reset();
        out_ready = 0;
        drive_in(1, 32'h400, 7'h13, 1, 0, 0);
        next_cyc();
        drive_in(1, 32'h404, 7'h13, 2, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready%0d", c), {31'd0, in_ready}, 0);
            chk($sformatf("bp_out_valid%0d", c), {31'd0, out_valid}, 1);
            chk($sformatf("bp_out_pc%0d", c), out_pc, 32'h400);
            chk($sformatf("bp_out_rd%0d", c), {27'd0, out_rd}, 1);
            next_cyc();
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 1);
        next_cyc();
        in_valid = 0;
        @(negedge clk);
        chk("bp_second_pc", out_pc, 32'h404);
        next_cyc();
        @(negedge clk);
        chk("bp_empty", {31'd0, out_valid}, 0);
        next_cyc();

        // Flush while stalled
        do_reset();
        out_ready = 1;
        drive_in(1, 32'h500, 7'h37, 4, 0, 0);
        next_cyc();
        drive_in(1, 32'h504, 7'h33, 5, 4, 0);
        next_cyc();
        in_valid = 0;
        @(negedge clk);
        chk("fl_stalled", {31'd0, out_valid}, 0);
        next_cyc();
        flush = 1;
        drive_in(1, 32'h508, 7'h13, 1, 0, 0);
        @(negedge clk);
        chk("fl_in_ready", {31'd0, in_ready}, 0);
        chk("fl_out_valid", {31'd0, out_valid}, 0);
        next_cyc();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("fl_after_out_valid", {31'd0, out_valid}, 0);
        chk("fl_after_in_ready", {31'd0, in_ready}, 1);
        chk("fl_busy", busy, 32'h10);
        chk("fl_stall_cycles", stall_cycles, CNT_EN ? 32'd1 : 32'd0);
        next_cyc();

        // Set/clear collision, then async reset mid-stall
        do_reset();
        out_ready = 1;
        drive_in(1, 32'h600, 7'h13, 3, 0, 0);
        next_cyc();
        wb_valid = 1; wb_rd = 3;
        drive_in(1, 32'h604, 7'h33, 9, 3, 0);
        next_cyc();
        wb_valid = 0; wb_rd = 0; in_valid = 0;
        @(negedge clk);
        chk("col_busy", busy, 32'h8);
        chk("col_stall", {31'd0, out_valid}, 0);
        #2;
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", {31'd0, out_valid}, 0);
        chk("arst_out_pc", out_pc, 0);
        chk("arst_stall_cycles", stall_cycles, 0);
        next_cyc();
        rst_n = 1;
        next_cyc();

        chk("sb_issue_count", npop, NV + 8);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
